nco_freq_calibrator: RTL and testbench

NCO_FREQ_CALIBRATOR -- requirements
Module: nco_freq_calibrator

---
 rtl/nco_freq_calibrator_pkg.sv | 23 ++
 rtl/nco_freq_calibrator_if.sv | 19 +
 rtl/nco_freq_calibrator_seq_udiv.sv | 70 +++++++
 rtl/nco_freq_calibrator.sv | 118 +++++++++++
 tb/tb_nco_freq_calibrator.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/nco_freq_calibrator_pkg.sv
// Shared state encoding, widths and defaults for the NCO frequency calibrator.
package nco_cal_pkg;

   localparam int          PHASE_W     = 32;
   localparam int          KEXP_DEF    = 20;
   localparam int unsigned TIMEOUT_DEF = 32'd1 << 26;

   typedef enum logic [2:0] {IDLE, ARM, GATE, DIV, DONE} calState_t;

   // a - b as a 33-bit signed value, clamped into the 32-bit signed range.
   function automatic logic [PHASE_W-1:0] satDiff(input logic [PHASE_W-1:0] a,
                                                  input logic [PHASE_W-1:0] b);
      logic [PHASE_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (!d[PHASE_W] && d[PHASE_W-1])
         satDiff = {1'b0, {(PHASE_W-1){1'b1}}};
      else if (d[PHASE_W] && !d[PHASE_W-1])
         satDiff = {1'b1, {(PHASE_W-1){1'b0}}};
      else
         satDiff = d[PHASE_W-1:0];
   endfunction

endpackage

// File: rtl/nco_freq_calibrator_if.sv
// Request/result bundle of the calibrator; master drives requests, slave returns results.
interface nco_freq_calibrator_if;
   import nco_cal_pkg::*;

   logic               start;
   logic               refIn;
   logic [PHASE_W-1:0] phaseIncNom;
   logic               busy;
   logic               done;
   logic [PHASE_W-1:0] phaseIncMeas;
   logic [PHASE_W-1:0] phaseErr;
   logic               timeout;
   logic               ovf;

   modport master (output start, refIn, phaseIncNom,
                   input  busy, done, phaseIncMeas, phaseErr, timeout, ovf);
   modport slave  (input  start, refIn, phaseIncNom,
                   output busy, done, phaseIncMeas, phaseErr, timeout, ovf);
endinterface

// File: rtl/nco_freq_calibrator_seq_udiv.sv
// Restoring divider: 33 quotient bits of a 64/32 divide, done pulses 33 cycles after start.
// Only numerator bits [32:0] are shifted; larger quotients saturate to all-ones.
module seq_udiv (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [63:0] numerator,
   input  logic [31:0] divisor,
   output logic [32:0] quotient,
   output logic        done
);
   logic [31:0] dvsr;
   logic [31:0] rem;
   logic [31:0] numLow;
   logic [32:0] quo;
   logic [5:0]  cnt;
   logic        sat;
   logic        active;
   logic [32:0] stepStart;
   logic [32:0] stepRun;

   // One restoring step: returns {quotient bit, new remainder}; requires r < d.
   function automatic logic [32:0] divStep(input logic [31:0] r, input logic b,
                                           input logic [31:0] d);
      logic [32:0] t;
      logic [32:0] s;
      t = {r, b};
      s = t - {1'b0, d};
      if (t >= {1'b0, d}) divStep = {1'b1, s[31:0]};
      else                divStep = {1'b0, t[31:0]};
   endfunction

   // The first step happens on the start cycle itself so 33 bits fit in 33 cycles.
   assign stepStart = divStep({1'b0, numerator[63:33]}, numerator[32], divisor);
   assign stepRun   = divStep(rem, numLow[31], dvsr);
   assign quotient  = sat ? '1 : quo;

   always_ff @(posedge CLK) begin
      if (RST) begin
         dvsr   <= '0;
         rem    <= '0;
         numLow <= '0;
         quo    <= '0;
         cnt    <= '0;
         sat    <= 1'b0;
         active <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            dvsr   <= divisor;
            sat    <= ({1'b0, numerator[63:33]} >= divisor);
            rem    <= stepStart[31:0];
            quo    <= {32'd0, stepStart[32]};
            numLow <= numerator[31:0];
            cnt    <= 6'd32;
            active <= 1'b1;
         end else if (active) begin
            rem    <= stepRun[31:0];
            quo    <= {quo[31:0], stepRun[32]};
            numLow <= {numLow[30:0], 1'b0};
            cnt    <= cnt - 6'd1;
            if (cnt == 6'd1) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/nco_freq_calibrator.sv
// Measures the NCO phase increment matching refIn over 2^KEXP reference periods.
// done follows the terminal reference edge by 34 cycles; start is ignored while busy.
module nco_freq_calibrator
   import nco_cal_pkg::*;
#(
   parameter int          KEXP        = KEXP_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
   input logic                  CLK,
   input logic                  RST,
   nco_freq_calibrator_if.slave bus
);
   localparam logic [63:0] NUMER    = 64'd1 << (PHASE_W + KEXP);
   localparam logic [31:0] GAP_LAST = 32'(TIMEOUT_CYC - 1);

   calState_t          state;
   logic               refSync1;
   logic               refSync2;
   logic               refPrev;
   logic               refEdge;
   logic [31:0]        cnt;
   logic [31:0]        cntInc;
   logic [31:0]        gap;
   logic [KEXP:0]      kCnt;
   logic [KEXP:0]      kNext;
   logic [PHASE_W-1:0] nomReg;
   logic [PHASE_W-1:0] measVal;
   logic [32:0]        quo;
   logic               divStart;
   logic               divDone;
   logic               gapExpired;

   assign refEdge    = refSync2 & ~refPrev;
   assign cntInc     = (cnt == '1) ? cnt : cnt + 32'd1;
   assign kNext      = kCnt + {{KEXP{1'b0}}, 1'b1};
   assign divStart   = (state == GATE) && refEdge && kNext[KEXP];
   assign gapExpired = !refEdge && (gap == GAP_LAST);
   assign measVal    = quo[32] ? '1 : quo[31:0];

   // cntInc includes the terminal cycle, so the divisor is the full edge-to-edge span.
   seq_udiv udiv (
      .CLK       (CLK),
      .RST       (RST),
      .start     (divStart),
      .numerator (NUMER),
      .divisor   (cntInc),
      .quotient  (quo),
      .done      (divDone)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= IDLE;
         refSync1         <= 1'b0;
         refSync2         <= 1'b0;
         refPrev          <= 1'b0;
         cnt              <= '0;
         kCnt             <= '0;
         gap              <= '0;
         nomReg           <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.phaseIncMeas <= '0;
         bus.phaseErr     <= '0;
         bus.timeout      <= 1'b0;
         bus.ovf          <= 1'b0;
      end else begin
         refSync1 <= bus.refIn;
         refSync2 <= refSync1;
         refPrev  <= refSync2;
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state       <= ARM;
               nomReg      <= bus.phaseIncNom;
               bus.busy    <= 1'b1;
               bus.timeout <= 1'b0;
               bus.ovf     <= 1'b0;
               gap         <= '0;
            end
            ARM, GATE: begin
               if (state == GATE) cnt <= cntInc;
               if (refEdge) begin
                  gap <= '0;
                  if (state == ARM) begin
                     state <= GATE;
                     cnt   <= '0;
                     kCnt  <= '0;
                  end else begin
                     kCnt <= kNext;
                     if (kNext[KEXP]) state <= DIV;
                  end
               end else if (gapExpired) begin
                  state            <= DONE;
                  bus.done         <= 1'b1;
                  bus.busy         <= 1'b0;
                  bus.timeout      <= 1'b1;
                  bus.phaseIncMeas <= '0;
                  bus.phaseErr     <= '0;
                  bus.ovf          <= 1'b0;
               end else begin
                  gap <= gap + 32'd1;
               end
            end
            DIV: if (divDone) begin
               state            <= DONE;
               bus.done         <= 1'b1;
               bus.busy         <= 1'b0;
               bus.phaseIncMeas <= measVal;
               bus.phaseErr     <= satDiff(measVal, nomReg);
               bus.ovf          <= quo[32];
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nco_freq_calibrator.sv
// Directed bench for nco_freq_calibrator with KEXP=4 and a 100-cycle edge timeout.
module tb_nco_freq_calibrator;
   import nco_cal_pkg::*;

   localparam int KX = 4;
   localparam int TO = 100;
   localparam int NPER = 1 << KX;

   typedef struct {
      logic [31:0] meas;
      logic [31:0] err;
      logic        to;
      logic        ov;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   int   rise[$];
   int   genReq = 0;
   int   genPeriod = 5;
   int   genPulses = 0;

   nco_freq_calibrator_if bus ();

   nco_freq_calibrator #(.KEXP(KX), .TIMEOUT_CYC(TO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #10 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Reference generator: genPulses rising edges of period genPeriod; each rise is
   // logged with the index of the first clock edge that samples it.
   initial begin : refGen
      int seen;
      seen = 0;
      bus.refIn = 1'b0;
      forever begin
         @(negedge CLK);
         if (genReq != seen) begin
            seen = genReq;
            for (int i = 0; i < genPulses; i++) begin
               if (i > 0) @(negedge CLK);
               bus.refIn = 1'b1;
               rise.push_back(cyc + 1);
               repeat (genPeriod / 2) @(negedge CLK);
               bus.refIn = 1'b0;
               repeat (genPeriod - genPeriod / 2 - 1) @(negedge CLK);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic waitDone(input int maxCyc, output bit seen, output int at);
      seen = 1'b0;
      at   = -1;
      for (int i = 0; i < maxCyc && !seen; i++) begin
         @(negedge CLK);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
   endtask

   task automatic compareResult(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_meas"},    bus.phaseIncMeas, e.meas);
         chk({tag, "_err"},     bus.phaseErr,     e.err);
         chk({tag, "_timeout"}, 32'(bus.timeout), 32'(e.to));
         chk({tag, "_ovf"},     32'(bus.ovf),     32'(e.ov));
         @(negedge CLK);
         chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
         chk({tag, "_busy_off"},   32'(bus.busy), 32'd0);
         chk({tag, "_meas_hold"},  bus.phaseIncMeas, e.meas);
      end
   endtask

   task automatic runMeas(input string tag, input int period, input logic [31:0] nom,
                          input bit poke);
      exp_t e;
      bit seen;
      int at;
      longint unsigned q;
      longint unsigned den;
      longint d;
      den = longint'(period) * longint'(NPER);
      q   = (64'd1 << (32 + KX)) / den;
      e.ov   = (q > 64'hFFFF_FFFF);
      e.meas = e.ov ? 32'hFFFF_FFFF : q[31:0];
      d = longint'(e.meas) - longint'(nom);
      if (d > 64'sd2147483647)       e.err = 32'h7FFF_FFFF;
      else if (d < -64'sd2147483648) e.err = 32'h8000_0000;
      else                           e.err = 32'(d);
      e.to = 1'b0;

      @(negedge CLK);
      bus.phaseIncNom = nom;
      bus.start = 1'b1;
      @(negedge CLK);
      bus.start = 1'b0;
      sb.push_back(e);
      chk({tag, "_busy_on_start"}, 32'(bus.busy), 32'd1);
      chk({tag, "_flags_cleared"}, {30'd0, bus.timeout, bus.ovf}, 32'd0);
      rise.delete();
      genPeriod = period;
      genPulses = NPER + 1;
      genReq++;
      if (poke) begin
         repeat (30) @(negedge CLK);
         chk({tag, "_in_gate"}, 32'(dut.state), 32'(GATE));
         bus.phaseIncNom = 32'd0;
         bus.start = 1'b1;
         @(negedge CLK);
         bus.start = 1'b0;
      end
      waitDone(period * NPER + 100, seen, at);
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (rise.size() > NPER)
         chk({tag, "_latency"}, 32'(at - (rise[NPER] + 1)), 32'd34);
      else
         chk({tag, "_rises"}, 32'(rise.size()), 32'(NPER + 1));
      chk({tag, "_cycles"}, dut.cnt, 32'(period * NPER));
      compareResult(tag);
      repeat (5) @(negedge CLK);
   endtask

   initial begin : stim
      bit   seen;
      int   at;
      int   armCyc;
      int   nDone;
      exp_t e;

      bus.start = 1'b0;
      bus.phaseIncNom = 32'd0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_busy",    32'(bus.busy),    32'd0);
      chk("rst_done",    32'(bus.done),    32'd0);
      chk("rst_meas",    bus.phaseIncMeas, 32'd0);
      chk("rst_err",     bus.phaseErr,     32'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      chk("rst_ovf",     32'(bus.ovf),     32'd0);

      bus.start = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      bus.start = 1'b0;
      repeat (2) @(negedge CLK);
      chk("start_in_reset_ignored", 32'(bus.busy), 32'd0);

      // 10 MHz reference, with a stray start mid-gate that must not disturb the result.
      runMeas("p5", 5, 32'd858999460, 1'b1);
      runMeas("p4", 4, 32'd1073741824, 1'b0);

      // Reference held low: timeout counted from ARM entry.
      @(negedge CLK);
      bus.phaseIncNom = 32'h1234_5678;
      bus.start = 1'b1;
      armCyc = cyc + 1;
      e = '{meas: 32'd0, err: 32'd0, to: 1'b1, ov: 1'b0};
      sb.push_back(e);
      @(negedge CLK);
      bus.start = 1'b0;
      waitDone(TO + 50, seen, at);
      chk("to_done_seen", 32'(seen), 32'd1);
      chk("to_latency", 32'(at - armCyc), 32'(TO));
      compareResult("to");

      runMeas("p2", 2, 32'h0000_0001, 1'b0);

      // Reset in the middle of the gate.
      @(negedge CLK);
      bus.phaseIncNom = 32'd5;
      bus.start = 1'b1;
      @(negedge CLK);
      bus.start = 1'b0;
      rise.delete();
      genPeriod = 5;
      genPulses = NPER + 1;
      genReq++;
      repeat (40) @(negedge CLK);
      chk("mid_rst_in_gate", 32'(dut.state), 32'(GATE));
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      RST = 1'b0;
      nDone = 0;
      repeat (150) begin
         @(negedge CLK);
         if (bus.done === 1'b1) nDone++;
      end
      chk("mid_rst_no_done", 32'(nDone), 32'd0);

      runMeas("restart", 4, 32'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
